// File: rtl/cache_ctrl_dm.sv
// rtl/cache_ctrl_dm.sv - direct-mapped read cache controller with whole-line DDR refill
// Valid bits, tag and line arrays are internal; hits are served from the array.
module cache_ctrl_dm #(
  parameter int ADDR_W     = 32,
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 128,
  parameter int LINES      = 16,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_re,
  input  logic [ADDR_W-1:0]            cpu_addr,
  output logic                         cpu_ready,
  output logic [WORD_W-1:0]            cpu_rdata,
  output logic                         busy,
  input  logic                         flush,
  output logic                         ddr_re,
  output logic [ADDR_W-1:0]            ddr_addr,
  input  logic                         ddr_valid,
  input  logic [LINE_WORDS*WORD_W-1:0] ddr_rdata,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt,
  output logic [2:0]                   state
);

  localparam int BO_W  = $clog2(WORD_W / 8);
  localparam int WO_W  = $clog2(LINE_WORDS);
  localparam int IX_W  = $clog2(LINES);
  localparam int OFF_W = WO_W + BO_W;
  localparam int TAG_W = ADDR_W - IX_W - OFF_W;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_RESP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_e;

  typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              ddr_re_q, ddr_re_d;
  logic [ADDR_W-1:0] ddr_addr_q, ddr_addr_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              flush_pend_q, flush_pend_d;

  // Tag and line storage carry no reset; valid_q alone qualifies their contents.
  logic [TAG_W-1:0]  tag_q  [LINES];
  line_t             data_q [LINES];

  logic [TAG_W-1:0]  req_tag;
  logic [IX_W-1:0]   req_idx;
  logic [WO_W-1:0]   req_wo;
  logic              lookup_hit;
  logic              refill_done;
  line_t             ddr_words;
  logic              unused_byte_off;

  assign req_tag         = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx         = addr_q[OFF_W +: IX_W];
  assign req_wo          = addr_q[BO_W +: WO_W];
  assign unused_byte_off = ^addr_q[BO_W-1:0];
  assign ddr_words       = ddr_rdata;
  assign lookup_hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign refill_done     = (state_q == S_REFILL) && ddr_valid;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rdata_q      <= '0;
      ddr_re_q     <= 1'b0;
      ddr_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      ddr_re_q     <= ddr_re_d;
      ddr_addr_q   <= ddr_addr_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (refill_done) begin
      data_q[req_idx] <= ddr_words;
      tag_q[req_idx]  <= req_tag;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    ddr_re_d     = ddr_re_q;
    ddr_addr_d   = ddr_addr_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q | flush;
    case (state_q)
      S_IDLE: begin
        // A pending or fresh flush wins; a simultaneous cpu_re is dropped.
        if (flush || flush_pend_q) begin
          state_d = S_FLUSH;
        end else if (cpu_re) begin
          addr_d  = cpu_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          rdata_d   = data_q[req_idx][req_wo];
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_RESP;
        end else begin
          miss_cnt_d = sat_inc(miss_cnt_q);
          ddr_re_d   = 1'b1;
          ddr_addr_d = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        // Requested word bypasses the array so the response needs no extra read cycle.
        if (ddr_valid) begin
          valid_d[req_idx] = 1'b1;
          rdata_d          = ddr_words[req_wo];
          ddr_re_d         = 1'b0;
          state_d          = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        valid_d      = '0;
        flush_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_ready = (state_q == S_RESP);
  assign cpu_rdata = rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign ddr_re    = ddr_re_q;
  assign ddr_addr  = ddr_addr_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb/tb_cache_ctrl_dm.sv - directed scoreboard bench for cache_ctrl_dm
module tb_cache_ctrl_dm;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 128;
  localparam int LINES      = 16;
  localparam int CNT_W      = 4;
  localparam int LW         = LINE_WORDS * WORD_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cpu_re = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              flush = 1'b0;
  logic              ddr_valid = 1'b0;
  logic [LW-1:0]     ddr_rdata = '1;
  logic              cpu_ready;
  logic [WORD_W-1:0] cpu_rdata;
  logic              busy;
  logic              ddr_re;
  logic [ADDR_W-1:0] ddr_addr;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [2:0]        state;

  cache_ctrl_dm #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS), .LINES(LINES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .busy(busy), .flush(flush), .ddr_re(ddr_re), .ddr_addr(ddr_addr),
    .ddr_valid(ddr_valid), .ddr_rdata(ddr_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .state(state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] la, input int w);
    logic [31:0] wv;
    wv = w;
    if (la == 32'h0000_1000 && w == 1) return 32'hDEAD_BEEF;
    return la ^ {wv[15:0], 16'h5A5A};
  endfunction

  function automatic logic [LW-1:0] line_of(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int i = 0; i < LINE_WORDS; i++) l[i*WORD_W +: WORD_W] = word_of(la, i);
    return l;
  endfunction

  function automatic logic [63:0] sat(input int v);
    return (v > 15) ? 64'd15 : 64'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_re = 1'b0; flush = 1'b0; ddr_valid = 1'b0;
    exp_hits = 0; exp_miss = 0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_counts(input string tag);
    check({tag, " hit_cnt"}, 64'(hit_cnt), sat(exp_hits));
    check({tag, " miss_cnt"}, 64'(miss_cnt), sat(exp_miss));
  endtask

  // One CPU read: push expectation, drive request, play DDR with dly wait cycles, pop on cpu_ready.
  task automatic do_read(input string tag, input logic [31:0] addr, input bit hit,
                         input int dly, input bit flush_mid, input bit noise);
    logic [31:0] la;
    logic [31:0] exp_word;
    int          wo;
    int          c;
    int          r;
    bit          seen_ready;
    bit          seen_ddr;
    la = {addr[31:9], 9'h000};
    wo = int'(addr[8:2]);
    exp_q.push_back(word_of(la, wo));
    if (hit) exp_hits++; else exp_miss++;
    seen_ready = 1'b0; seen_ddr = 1'b0; r = 0;
    cpu_addr = addr; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0; c = 1;
    while (c < 200) begin
      if (cpu_ready) begin seen_ready = 1'b1; break; end
      cpu_re = noise;
      if (noise) cpu_addr = 32'h0000_5004;
      flush = 1'b0; ddr_valid = 1'b0; ddr_rdata = '1;
      if (ddr_re) begin
        if (!seen_ddr) check({tag, " ddr_addr"}, 64'(ddr_addr), 64'(la));
        seen_ddr = 1'b1;
        if (flush_mid && r == 0) flush = 1'b1;
        if (r == dly) begin ddr_valid = 1'b1; ddr_rdata = line_of(la); end
        r++;
      end
      tick();
      c++;
    end
    cpu_re = 1'b0; flush = 1'b0; ddr_valid = 1'b0; ddr_rdata = '1;
    check({tag, " ready seen"}, 64'(seen_ready), 64'd1);
    check({tag, " latency"}, 64'(c), hit ? 64'd2 : 64'(3 + dly));
    check({tag, " ddr used"}, 64'(seen_ddr), 64'(!hit));
    exp_word = 32'hx;
    if (seen_ready && exp_q.size() > 0) begin
      exp_word = exp_q.pop_front();
      check({tag, " rdata"}, 64'(cpu_rdata), 64'(exp_word));
    end
    tick();
    check({tag, " ready pulse"}, 64'(cpu_ready), 64'd0);
    check({tag, " rdata held"}, 64'(cpu_rdata), 64'(exp_word));
  endtask

  initial begin
    // T1 cold miss, with reset-state checks first
    do_reset();
    check("rst state", 64'(state), 64'd1);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ready", 64'(cpu_ready), 64'd0);
    check("rst rdata", 64'(cpu_rdata), 64'd0);
    check("rst ddr_re", 64'(ddr_re), 64'd0);
    check("rst ddr_addr", 64'(ddr_addr), 64'd0);
    check_counts("rst");
    do_read("T1", 32'h0000_1004, 1'b0, 5, 1'b0, 1'b0);
    check_counts("T1");

    // T2 hit on the freshly loaded line
    do_read("T2", 32'h0000_1008, 1'b1, 0, 1'b0, 1'b0);
    check_counts("T2");

    // T3 conflict on index 8
    do_read("T3a", 32'h0000_1000 + LINES * 512, 1'b0, 2, 1'b0, 1'b0);
    do_read("T3b", 32'h0000_1000, 1'b0, 0, 1'b0, 1'b0);
    do_read("T3c", 32'h0000_11FC, 1'b1, 0, 1'b0, 1'b0);
    check_counts("T3");

    // T4 flush arriving mid-refill
    do_read("T4a", 32'h0000_4208, 1'b0, 3, 1'b1, 1'b0);
    tick();
    check("T4 flush state", 64'(state), 64'd5);
    tick();
    check("T4 idle after flush", 64'(state), 64'd1);
    do_read("T4b", 32'h0000_4208, 1'b0, 1, 1'b0, 1'b0);
    do_read("T4c", 32'h0000_1004, 1'b0, 0, 1'b0, 1'b0);
    check_counts("T4");

    // T6 ignored traffic: cpu_re while busy, ddr_valid while idle
    do_read("T6a", 32'h0000_3004, 1'b0, 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      ddr_valid = 1'b1; ddr_rdata = '0;
      tick();
      check("T6 idle ready", 64'(cpu_ready), 64'd0);
      check("T6 idle state", 64'(state), 64'd1);
    end
    ddr_valid = 1'b0; ddr_rdata = '1;
    check_counts("T6 idle");
    do_read("T6b", 32'h0000_3008, 1'b1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) do_read("T6sat", 32'h0000_3000 + 32'(i * 4), 1'b1, 0, 1'b0, 1'b0);
    check_counts("T6 sat");
    check("T6 hit_cnt saturated", 64'(hit_cnt), 64'd15);

    // T5 reset during refill, late ddr_valid afterwards
    do_reset();
    cpu_addr = 32'h0000_2104; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
    tick();
    check("T5 in refill", 64'(ddr_re), 64'd1);
    tick();
    reset = 1'b1; exp_hits = 0; exp_miss = 0;
    #1;
    check("T5 async ddr_re", 64'(ddr_re), 64'd0);
    check("T5 async state", 64'(state), 64'd1);
    tick();
    reset = 1'b0;
    tick(); tick();
    ddr_valid = 1'b1; ddr_rdata = line_of(32'h0000_2000);
    tick();
    ddr_valid = 1'b0; ddr_rdata = '1;
    check("T5 late valid state", 64'(state), 64'd1);
    check("T5 late valid ddr_re", 64'(ddr_re), 64'd0);
    check("T5 late valid ready", 64'(cpu_ready), 64'd0);
    check_counts("T5 late");
    do_read("T5", 32'h0000_2104, 1'b0, 1, 1'b0, 1'b0);
    check_counts("T5");

    check("scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
